// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, op-code encoding and the op legality check.
package alu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int OPW_DEF  = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1101;
  localparam logic [3:0] ALU_SRL = 4'b1110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic ok;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
      ALU_SRA, ALU_XOR, ALU_SLL, ALU_SRL: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction
endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way combinational grant for the shared ALU; round-robin by default,
// fixed priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0_vld,
  input  logic i_req1_vld,
  output logic o_gnt0,
  output logic o_gnt1
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = i_clk ^ i_rst;
  assign o_gnt0   = i_req0_vld;
  assign o_gnt1   = i_req1_vld & ~i_req0_vld;
`else
  // r_rr_ptr names the requester that wins the next tie
  logic r_rr_ptr;
  assign o_gnt0 = i_req0_vld & (~i_req1_vld | ~r_rr_ptr);
  assign o_gnt1 = i_req1_vld & ~o_gnt0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= 1'b0;
    end else if (o_gnt0 | o_gnt1) begin
      r_rr_ptr <= o_gnt0;
    end
  end
`endif
endmodule

// File: rtl/alu_share_arb.sv
// Shares one integer ALU between the execute path (req0) and an auxiliary unit (req1);
// 2-cycle request-to-response, no response backpressure. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp0_err,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic            rsp1_err,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);
  logic            w_gnt0, w_gnt1, w_xfer;
  logic [OPW-1:0]  w_sel_op;
  logic [XLEN-1:0] w_sel_a, w_sel_b;

  logic            r_iss_vld, r_iss_id, r_iss_ill;
  logic [OPW-1:0]  r_iss_op;
  logic [XLEN-1:0] r_iss_a, r_iss_b;

  logic            r_rsp_vld  [2];
  logic [XLEN-1:0] r_rsp_res  [2];
  logic            r_rsp_zero [2];
  logic            r_rsp_err  [2];

  alu_rr_arb2 u_arb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req0_vld (req0_valid),
    .i_req1_vld (req1_valid),
    .o_gnt0     (w_gnt0),
    .o_gnt1     (w_gnt1)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_xfer     = w_gnt0 | w_gnt1;
  assign w_sel_op   = w_gnt1 ? req1_op : req0_op;
  assign w_sel_a    = w_gnt1 ? req1_a  : req0_a;
  assign w_sel_b    = w_gnt1 ? req1_b  : req0_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_vld <= 1'b0;
      r_iss_id  <= 1'b0;
      r_iss_ill <= 1'b0;
      r_iss_op  <= ALU_NOP;
      r_iss_a   <= '0;
      r_iss_b   <= '0;
    end else begin
      r_iss_vld <= w_xfer;
      if (w_xfer) begin
        r_iss_id  <= w_gnt1;
        r_iss_ill <= ~is_legal_op(w_sel_op);
        r_iss_op  <= w_sel_op;
        r_iss_a   <= w_sel_a;
        r_iss_b   <= w_sel_b;
      end
    end
  end

  // An illegal code never reaches the ALU; it sees a NOP with zeroed operands instead
  always_comb begin
    alu_op = ALU_NOP;
    alu_a  = '0;
    alu_b  = '0;
    if (r_iss_vld && !r_iss_ill) begin
      alu_op = r_iss_op;
      alu_a  = r_iss_a;
      alu_b  = r_iss_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_rsp_vld[i]  <= 1'b0;
        r_rsp_res[i]  <= '0;
        r_rsp_zero[i] <= 1'b0;
        r_rsp_err[i]  <= 1'b0;
      end
    end else begin
      r_rsp_vld[0] <= r_iss_vld & ~r_iss_id;
      r_rsp_vld[1] <= r_iss_vld & r_iss_id;
      if (r_iss_vld) begin
        r_rsp_res[r_iss_id]  <= r_iss_ill ? '0 : alu_result;
        r_rsp_zero[r_iss_id] <= r_iss_ill ? 1'b0 : alu_zero;
        r_rsp_err[r_iss_id]  <= r_iss_ill;
      end
    end
  end

  assign rsp0_valid  = r_rsp_vld[0];
  assign rsp0_result = r_rsp_res[0];
  assign rsp0_zero   = r_rsp_zero[0];
  assign rsp0_err    = r_rsp_err[0];
  assign rsp1_valid  = r_rsp_vld[1];
  assign rsp1_result = r_rsp_res[1];
  assign rsp1_zero   = r_rsp_zero[1];
  assign rsp1_err    = r_rsp_err[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// Randomised bench for alu_share_arb against a transaction-queue reference model.
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return $unsigned($signed(a) >>> b[4:0]);
      4'b1100: return a ^ b;
      4'b1101: return a << b[4:0];
      4'b1110: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1110};
  endfunction

  // Stand-in ALU attached to the DUT's ALU port
  always_comb begin
    alu_result = ref_alu(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
  end

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        zero, err;
    int          due;
  } txn_t;

  txn_t        pend[$];
  int          ecount;
  bit          mptr;
  bit          exp_g0, exp_g1;
  logic [31:0] held_res  [2];
  logic        held_zero [2];
  logic        held_err  [2];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mptr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      held_res[i] = 32'd0; held_zero[i] = 1'b0; held_err[i] = 1'b0;
    end
  endtask

  // Compare everything visible now against the model's view of the last edge
  task automatic check_now();
    txn_t cur, iss;
    bit   have_rsp = 0, have_iss = 0;
    bit   ev;
    foreach (pend[i]) begin
      if (pend[i].due == ecount)     begin cur = pend[i]; have_rsp = 1; end
      if (pend[i].due == ecount + 1) begin iss = pend[i]; have_iss = 1; end
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g0 = req0_valid;
`else
    exp_g0 = req0_valid && (!req1_valid || !mptr);
`endif
    exp_g1 = req1_valid && !exp_g0;
    chk_eq("ready0", {31'd0, req0_ready}, {31'd0, exp_g0});
    chk_eq("ready1", {31'd0, req1_ready}, {31'd0, exp_g1});
    if (have_iss && ref_legal(iss.op)) begin
      chk_eq("alu_op", {28'd0, alu_op}, {28'd0, iss.op});
      chk_eq("alu_a", alu_a, iss.a);
      chk_eq("alu_b", alu_b, iss.b);
    end else begin
      chk_eq("alu_op_nop", {28'd0, alu_op}, 32'hF);
      chk_eq("alu_a_zero", alu_a, 32'd0);
      chk_eq("alu_b_zero", alu_b, 32'd0);
    end
    if (have_rsp) begin
      held_res[cur.id] = cur.res; held_zero[cur.id] = cur.zero; held_err[cur.id] = cur.err;
    end
    ev = have_rsp && cur.id == 0;
    chk_eq("rsp0_valid",  {31'd0, rsp0_valid}, {31'd0, ev});
    chk_eq("rsp0_result", rsp0_result, held_res[0]);
    chk_eq("rsp0_zero",   {31'd0, rsp0_zero}, {31'd0, held_zero[0]});
    chk_eq("rsp0_err",    {31'd0, rsp0_err},  {31'd0, held_err[0]});
    ev = have_rsp && cur.id == 1;
    chk_eq("rsp1_valid",  {31'd0, rsp1_valid}, {31'd0, ev});
    chk_eq("rsp1_result", rsp1_result, held_res[1]);
    chk_eq("rsp1_zero",   {31'd0, rsp1_zero}, {31'd0, held_zero[1]});
    chk_eq("rsp1_err",    {31'd0, rsp1_err},  {31'd0, held_err[1]});
  endtask

  // Advance the model across the coming clock edge
  task automatic model_edge();
    txn_t t;
    if (rst) begin
      model_reset();
    end else begin
      while (pend.size() > 0 && pend[0].due <= ecount) void'(pend.pop_front());
      if (exp_g0 || exp_g1) begin
        t.id   = exp_g1 ? 1 : 0;
        t.op   = exp_g1 ? req1_op : req0_op;
        t.a    = exp_g1 ? req1_a  : req0_a;
        t.b    = exp_g1 ? req1_b  : req0_b;
        t.err  = !ref_legal(t.op);
        t.res  = t.err ? 32'd0 : ref_alu(t.op, t.a, t.b);
        t.zero = !t.err && (t.res == 32'd0);
        t.due  = ecount + 2;
        pend.push_back(t);
        mptr = (t.id == 0);
      end
    end
    ecount++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
  endtask

  task automatic idle(input int n);
    drive(0, 4'hF, 0, 0, 0, 4'hF, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [3:0] legal_ops [9] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hC, 4'hD, 4'hE};

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return legal_ops[$urandom_range(0, 8)];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    drive(1, 4'h2, 1, 2, 1, 4'h2, 3, 4);
    @(posedge clk); #1;
    ecount = 1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();                         // both valid: first grant must go to requester 0
    idle(3);

    drive(1, 4'h2, 5, 7, 0, 4'hF, 0, 0);
    cycle();
    idle(3);
    chk_eq("add_result_held", rsp0_result, 32'd12);
    chk_eq("add_zero_held", {31'd0, rsp0_zero}, 32'd0);

    drive(1, 4'h6, 9, 9, 1, 4'hC, 32'hF0, 32'h0F);
    for (int i = 0; i < 4; i++) cycle();
    idle(3);
    chk_eq("sub_zero_held", {31'd0, rsp0_zero}, 32'd1);
`ifndef ALU_ARB_FIXED_PRIO_EN
    chk_eq("xor_result_held", rsp1_result, 32'hFF);
`endif

    drive(0, 4'hF, 0, 0, 1, 4'h3, 1, 1);
    cycle();
    idle(3);
    chk_eq("illegal_err_held", {31'd0, rsp1_err}, 32'd1);

    drive(1, 4'hD, 1, 4, 0, 4'hF, 0, 0);
    cycle();
    drive(0, 4'hF, 0, 0, 0, 4'hF, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle(3);
    chk_eq("midflight_result", rsp0_result, 32'd0);

    drive(1, 4'h7, 32'hFFFF_FFFF, 1, 0, 4'hF, 0, 0);
    cycle();
    drive(1, 4'h8, 32'h8000_0000, 4, 0, 4'hF, 0, 0);
    cycle();
    drive(1, 4'h0, 32'hC, 32'hA, 0, 4'hF, 0, 0);
    cycle();
    idle(3);
    chk_eq("b2b_last_result", rsp0_result, 32'h8);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 2) != 0, rand_op(), rand_operand(), rand_operand(),
            $urandom_range(0, 2) != 0, rand_op(), rand_operand(), rand_operand());
      cycle();
    end
    rst = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
